// File: rtl/nn_pkg.sv
// nn_pkg: encodings and helpers shared by the NN pipeline stages.
//   act_e    : activation select codes (2'b11 behaves as pass)
//   state_e  : batch accumulator FSM states
//   saturate : clamp a signed value to a w-bit two's-complement range
package nn_pkg;

    typedef enum logic [1:0] {
        ACT_PASS  = 2'b00,
        ACT_RELU  = 2'b01,
        ACT_HTANH = 2'b10
    } act_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_DRAIN
    } state_e;

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

endpackage

// File: rtl/batch_acc_act_if.sv
// batch_acc_act_if: stream bundle of the batch accumulator.
//   sum side    : sum_valid, sum_in, bias_in into the block; bias_req out of it
//   result side : dout, dout_valid out of the block; dout_ready into it
//   slave  = the accumulator block
//   master = adder tree plus result consumer
interface batch_acc_act_if #(parameter int DW = 16);
    logic          sum_valid;
    logic [DW-1:0] sum_in;
    logic [DW-1:0] bias_in;
    logic          bias_req;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;

    modport slave (
        input  sum_valid, sum_in, bias_in, dout_ready,
        output bias_req, dout, dout_valid
    );

    modport master (
        output sum_valid, sum_in, bias_in, dout_ready,
        input  bias_req, dout, dout_valid
    );
endinterface

// File: rtl/res_fifo.sv
// res_fifo: synchronous result FIFO; head is read straight from the storage registers.
//   clk, rst_n        : clock, asynchronous active-low reset (clears pointers and storage)
//   wr_en, wr_data    : push request; accepted when not full or when a pop frees a slot
//   rd_en             : pop request; ignored when empty
//   rd_data, rd_valid : head entry and not-empty flag
//   full              : all DEPTH entries occupied
module res_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         rd_valid,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp;
    logic [AW:0]  rp;
    logic         empty;
    logic         push;
    logic         pop;

    // pointers carry one wrap bit: equal => empty, only wrap bit differs => full
    assign empty    = wp == rp;
    assign full     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign pop      = rd_en && !empty;
    assign push     = wr_en && (!full || pop);
    assign rd_valid = !empty;
    assign rd_data  = mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) mem[wp[AW-1:0]] <= wr_data;
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
        end
    end
endmodule

// File: rtl/batch_acc_act.sv
// batch_acc_act: accumulates cfg_batches channel sums per neuron, adds the bias,
// applies the selected activation and queues results in an output FIFO.
//   clk, rst_n               : clock, asynchronous active-low reset
//   start                    : pulse in idle latches cfg_*/act_sel and begins a layer
//   cfg_batches, cfg_neurons : chunks per neuron, neurons per layer (0 acts as 1)
//   act_sel                  : 00 pass, 01 ReLU, 10 hard-tanh, 11 pass
//   busy, done, overrun      : layer active, final-neuron write pulse, sticky drop flag
//   bus (slave)              : sum stream in, bias_req out, result stream out
// Build option: define BATCH_ACC_SAT_EN to saturate the accumulator and the final
// narrowing; otherwise both wrap in two's complement.
module batch_acc_act
    import nn_pkg::*;
#(
    parameter int DW         = 16,
    parameter int FRAC       = 12,
    parameter int CNT_W      = 8,
    parameter int ACC_W      = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_batches,
    input  logic [CNT_W-1:0] cfg_neurons,
    input  logic [1:0]       act_sel,
    output logic             busy,
    output logic             done,
    output logic             overrun,
    batch_acc_act_if.slave   bus
);
    localparam logic signed [ACC_W-1:0] ONE = ACC_W'(1) <<< FRAC;

    state_e                   state;
    state_e                   state_nxt;
    logic [CNT_W-1:0]         b_lim;
    logic [CNT_W-1:0]         n_lim;
    logic [CNT_W-1:0]         batch_cnt;
    logic [CNT_W-1:0]         neuron_cnt;
    logic [1:0]               act_q;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_base;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  sum_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  s1;
    logic signed [ACC_W-1:0]  s1_next;
    logic signed [ACC_W-1:0]  act_val;
    logic [DW-1:0]            act_narrow;
    logic [DW-1:0]            s2;
    logic                     s1_v;
    logic                     s1_last;
    logic                     s2_v;
    logic                     s2_last;
    logic                     take;
    logic                     last_chunk;
    logic                     last_neuron;
    logic                     pop;
    logic                     fifo_full;

    assign take        = (state == ST_ACC) && bus.sum_valid;
    assign last_chunk  = batch_cnt == b_lim - 1'b1;
    assign last_neuron = neuron_cnt == n_lim - 1'b1;
    assign sum_ext     = ACC_W'(signed'(bus.sum_in));
    assign bias_ext    = ACC_W'(signed'(bus.bias_in));
    // a new neuron restarts from its first sum instead of needing a clear cycle
    assign acc_base    = (batch_cnt == '0) ? '0 : acc;

    assign act_val = (act_q == ACT_RELU)  ? ((s1 < 0) ? '0 : s1) :
                     (act_q == ACT_HTANH) ? ((s1 > ONE) ? ONE : (s1 < -ONE) ? -ONE : s1) :
                     s1;

`ifdef BATCH_ACC_SAT_EN
    assign acc_next   = ACC_W'(saturate(64'(acc_base) + 64'(sum_ext), ACC_W));
    assign s1_next    = ACC_W'(saturate(64'(acc_next) + 64'(bias_ext), ACC_W));
    assign act_narrow = DW'(saturate(64'(act_val), DW));
`else
    assign acc_next   = acc_base + sum_ext;
    assign s1_next    = acc_next + bias_ext;
    assign act_narrow = act_val[DW-1:0];
`endif

    assign bus.bias_req = (state == ST_ACC) && last_chunk;
    assign pop          = bus.dout_valid && bus.dout_ready;
    assign done         = s2_v && s2_last;

    // busy falls as soon as the pipeline is empty, one cycle before the FSM reaches idle
    always_comb begin
        state_nxt = state;
        busy      = (state == ST_ACC) || ((state == ST_DRAIN) && (s1_v || s2_v));
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_ACC;
            ST_ACC:   if (take && last_chunk && last_neuron) state_nxt = ST_DRAIN;
            ST_DRAIN: if (!s1_v && !s2_v) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_lim      <= '0;
            n_lim      <= '0;
            act_q      <= '0;
            batch_cnt  <= '0;
            neuron_cnt <= '0;
            acc        <= '0;
            s1         <= '0;
            s1_v       <= 1'b0;
            s1_last    <= 1'b0;
            s2         <= '0;
            s2_v       <= 1'b0;
            s2_last    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && start) begin
                b_lim      <= (cfg_batches == '0) ? CNT_W'(1) : cfg_batches;
                n_lim      <= (cfg_neurons == '0) ? CNT_W'(1) : cfg_neurons;
                act_q      <= act_sel;
                batch_cnt  <= '0;
                neuron_cnt <= '0;
                acc        <= '0;
                overrun    <= 1'b0;
            end
            if (take) begin
                acc       <= acc_next;
                batch_cnt <= last_chunk ? '0 : batch_cnt + 1'b1;
                if (last_chunk) neuron_cnt <= neuron_cnt + 1'b1;
                if (last_chunk) s1 <= s1_next;
            end
            s1_v    <= take && last_chunk;
            s1_last <= take && last_chunk && last_neuron;
            s2      <= act_narrow;
            s2_v    <= s1_v;
            s2_last <= s1_last;
            // a simultaneous pop frees a slot, so only a write into a full, non-popping FIFO drops
            if (s2_v && fifo_full && !pop) overrun <= 1'b1;
        end
    end

    res_fifo #(
        .W     (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (s2_v),
        .wr_data  (s2),
        .rd_en    (bus.dout_ready),
        .rd_data  (bus.dout),
        .rd_valid (bus.dout_valid),
        .full     (fifo_full)
    );
endmodule

// File: tb/tb_batch_acc_act.sv
// tb_batch_acc_act: randomized self-checking bench for batch_acc_act against a behavioural model.
module tb_batch_acc_act;
    import nn_pkg::*;

    localparam int DW    = 16;
    localparam int FRAC  = 12;
    localparam int CNT_W = 8;
    localparam int ACC_W = 24;
    localparam int DEPTH = 4;
    localparam longint AHALF = 64'sd1 <<< (ACC_W - 1);
    localparam longint ONE   = 64'sd1 <<< FRAC;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] cfg_batches = '0;
    logic [CNT_W-1:0] cfg_neurons = '0;
    logic [1:0]       act_sel = 2'b00;
    logic             busy;
    logic             done;
    logic             overrun;
    int               n_checks = 0;
    int               n_fail = 0;
    int               done_cnt = 0;
    logic [DW-1:0]    got[$];
    logic [DW-1:0]    exp_q[$];

    batch_acc_act_if #(.DW(DW)) bus();

    batch_acc_act #(
        .DW(DW), .FRAC(FRAC), .CNT_W(CNT_W), .ACC_W(ACC_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_batches(cfg_batches),
        .cfg_neurons(cfg_neurons), .act_sel(act_sel), .busy(busy), .done(done),
        .overrun(overrun), .bus(bus)
    );

    always #5 clk = ~clk;

    // inputs change 1 time unit after posedge, so the falling edge sees settled pop decisions
    always @(negedge clk) begin
        if (bus.dout_valid && bus.dout_ready) got.push_back(bus.dout);
        if (done) done_cnt++;
    end

    function automatic longint fit(input longint v);
`ifdef BATCH_ACC_SAT_EN
        return (v > AHALF - 1) ? AHALF - 1 : (v < -AHALF) ? -AHALF : v;
`else
        return ((v + AHALF) & (2 * AHALF - 1)) - AHALF;
`endif
    endfunction

    function automatic longint sx(input logic [DW-1:0] x);
        return longint'($signed(x));
    endfunction

    function automatic logic [DW-1:0] model(input longint sums[$], input longint bias, input logic [1:0] act);
        longint acc;
        longint v;
        acc = 0;
        foreach (sums[i]) acc = fit(acc + sums[i]);
        v = fit(acc + bias);
        if (act == 2'b01 && v < 0) v = 0;
        if (act == 2'b10) v = (v > ONE) ? ONE : (v < -ONE) ? -ONE : v;
`ifdef BATCH_ACC_SAT_EN
        v = (v > 32767) ? 32767 : (v < -32768) ? -32768 : v;
`endif
        return DW'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_layer(input int b, input int n, input int a);
        cfg_batches = CNT_W'(b);
        cfg_neurons = CNT_W'(n);
        act_sel = 2'(a);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chunk(input logic [DW-1:0] s, input logic [DW-1:0] bias);
        bus.sum_valid = 1'b1;
        bus.sum_in = s;
        bus.bias_in = bias;
        tick();
        bus.sum_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int k;
        k = 0;
        bus.dout_ready = 1'b1;
        while ((got.size() < n || busy) && k < 200) begin
            tick();
            k++;
        end
        n_checks++;
        if (got.size() < n || busy) begin
            n_fail++;
            $display("FAIL wait_results: got %0d results busy=%0b, required %0d results and idle", got.size(), busy, n);
        end
        repeat (3) tick();
    endtask

    task automatic compare_results(input string tag);
        n_checks++;
        if (got.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d results, required %0d", tag, got.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s_data[%0d]: got %h, required %h", tag, i, (i < got.size()) ? got[i] : 'x, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b required 0", overrun); end
        n_checks++; if (bus.bias_req !== 1'b0) begin n_fail++; $display("FAIL reset_bias_req: got %b required 0", bus.bias_req); end
        n_checks++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout_valid: got %b required 0", bus.dout_valid); end
        n_checks++; if (bus.dout !== '0) begin n_fail++; $display("FAIL reset_dout: got %h required 0000", bus.dout); end
        rst_n = 1'b1;
        tick();
        // sums arriving while idle must be ignored
        chunk(16'h1234, 16'h0001);
        repeat (4) tick();
        n_checks++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL idle_sum_ignored: dout_valid %b required 0", bus.dout_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b required 0", busy); end
    endtask

    task automatic test_pass_timing();
        longint q[$];
        logic [DW-1:0] want;
        q.push_back(sx(16'h0200));
        q.push_back(sx(16'h0300));
        want = model(q, sx(16'h0100), 2'b00);
        bus.dout_ready = 1'b0;
        begin_layer(2, 1, ACT_PASS);
        bus.sum_valid = 1'b1; bus.sum_in = 16'h0200; bus.bias_in = 16'h0000;
        n_checks++; if (bus.bias_req !== 1'b0) begin n_fail++; $display("FAIL pass_bias_req_first: got %b required 0", bus.bias_req); end
        tick();
        bus.sum_in = 16'h0300; bus.bias_in = 16'h0100;
        n_checks++; if (bus.bias_req !== 1'b1) begin n_fail++; $display("FAIL pass_bias_req_last: got %b required 1", bus.bias_req); end
        tick();
        bus.sum_valid = 1'b0;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL pass_done_T1: got %b required 0", done); end
        tick();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL pass_done_T2: got %b required 1", done); end
        n_checks++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL pass_valid_T2: got %b required 0", bus.dout_valid); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pass_busy_T2: got %b required 1", busy); end
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL pass_done_T3: got %b required 0", done); end
        n_checks++; if (bus.dout_valid !== 1'b1) begin n_fail++; $display("FAIL pass_valid_T3: got %b required 1", bus.dout_valid); end
        n_checks++; if (bus.dout !== want) begin n_fail++; $display("FAIL pass_dout: got %h required %h", bus.dout, want); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pass_busy_T3: got %b required 0", busy); end
        bus.dout_ready = 1'b1;
        tick();
        bus.dout_ready = 1'b0;
        n_checks++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL pass_pop: dout_valid %b required 0", bus.dout_valid); end
        repeat (2) tick();
        got.delete();
    endtask

    task automatic run_single_chunk_layer(input logic [DW-1:0] sums[$], input int a, input string tag);
        longint q[$];
        int d0;
        got.delete(); exp_q.delete();
        d0 = done_cnt;
        bus.dout_ready = 1'b1;
        begin_layer(1, sums.size(), a);
        foreach (sums[i]) begin
            q.delete();
            q.push_back(sx(sums[i]));
            exp_q.push_back(model(q, 0, 2'(a)));
            chunk(sums[i], 16'h0000);
        end
        wait_results(sums.size());
        compare_results(tag);
        n_checks++; if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL %s_done: %0d pulses, required 1", tag, done_cnt - d0); end
    endtask

    task automatic test_relu_back_to_back();
        logic [DW-1:0] s[$];
        s.push_back(16'h0100); s.push_back(16'hFF00); s.push_back(16'h0050);
        run_single_chunk_layer(s, ACT_RELU, "relu");
    endtask

    task automatic test_htanh();
        logic [DW-1:0] s[$];
        s.push_back(16'h3000); s.push_back(16'hC000); s.push_back(16'h0800);
        run_single_chunk_layer(s, ACT_HTANH, "htanh");
    endtask

    task automatic test_saturation();
        longint q[$];
        got.delete(); exp_q.delete();
        begin_layer(4, 1, ACT_PASS);
        repeat (4) begin
            q.push_back(sx(16'h7000));
            chunk(16'h7000, 16'h0000);
        end
        exp_q.push_back(model(q, 0, 2'b00));
        wait_results(1);
        compare_results("narrow");
    endtask

    task automatic test_overrun();
        longint q[$];
        logic [DW-1:0] s;
        logic [DW-1:0] b;
        int d0;
        got.delete(); exp_q.delete();
        d0 = done_cnt;
        bus.dout_ready = 1'b0;
        begin_layer(1, 6, ACT_PASS);
        for (int i = 0; i < 6; i++) begin
            s = DW'($urandom);
            b = DW'($urandom);
            q.delete();
            q.push_back(sx(s));
            if (i < DEPTH) exp_q.push_back(model(q, sx(b), 2'b00));
            chunk(s, b);
        end
        repeat (4) tick();
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b required 1", overrun); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ovr_busy: got %b required 0", busy); end
        n_checks++; if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL ovr_done: %0d pulses, required 1", done_cnt - d0); end
        n_checks++; if (got.size() !== 0) begin n_fail++; $display("FAIL ovr_held: %0d popped while not ready, required 0", got.size()); end
        wait_results(DEPTH);
        repeat (3) tick();
        compare_results("ovr");
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b required 1", overrun); end
        begin_layer(1, 1, ACT_PASS);
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b required 0", overrun); end
        chunk(16'h0001, 16'h0000);
        wait_results(DEPTH + 1);
    endtask

    task automatic test_reset_mid_layer();
        longint q[$];
        logic [DW-1:0] e, f, g;
        got.delete(); exp_q.delete();
        bus.dout_ready = 1'b0;
        begin_layer(2, 2, ACT_PASS);
        chunk(16'h0111, 16'h0000);
        chunk(16'h0222, 16'h0010);
        chunk(16'h0333, 16'h0000);
        repeat (3) tick();
        n_checks++; if (bus.dout_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid: got %b required 1", bus.dout_valid); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b required 0", bus.dout_valid); end
        n_checks++; if (bus.dout !== '0) begin n_fail++; $display("FAIL rmid_dout: got %h required 0000", bus.dout); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b required 0", busy); end
        n_checks++; if (bus.bias_req !== 1'b0) begin n_fail++; $display("FAIL rmid_bias_req: got %b required 0", bus.bias_req); end
        tick();
        rst_n = 1'b1;
        tick();
        e = DW'($urandom); f = DW'($urandom); g = DW'($urandom);
        q.push_back(sx(e)); q.push_back(sx(f));
        exp_q.push_back(model(q, sx(g), 2'b00));
        begin_layer(2, 1, ACT_PASS);
        chunk(e, 16'h0000);
        chunk(f, g);
        wait_results(1);
        compare_results("rmid");
    endtask

    task automatic test_random();
        int b, n, a, eb, en;
        logic [DW-1:0] s;
        logic [DW-1:0] bias;
        longint q[$];
        for (int r = 0; r < 10; r++) begin
            b = $urandom_range(0, 4); n = $urandom_range(0, 4); a = $urandom_range(0, 3);
            eb = (b == 0) ? 1 : b;
            en = (n == 0) ? 1 : n;
            got.delete(); exp_q.delete();
            begin_layer(b, n, a);
            for (int i = 0; i < en; i++) begin
                q.delete();
                bias = DW'($urandom);
                for (int j = 0; j < eb; j++) begin
                    repeat ($urandom_range(0, 2)) begin
                        bus.dout_ready = 1'($urandom_range(0, 1));
                        tick();
                    end
                    s = DW'($urandom);
                    q.push_back(sx(s));
                    // a start pulse and new cfg mid-layer must be ignored
                    start = (i == 0 && j == 0);
                    cfg_batches = CNT_W'($urandom);
                    bus.dout_ready = 1'($urandom_range(0, 1));
                    chunk(s, (j == eb - 1) ? bias : DW'($urandom));
                    start = 1'b0;
                end
                exp_q.push_back(model(q, sx(bias), 2'(a)));
            end
            wait_results(en);
            compare_results($sformatf("rand%0d", r));
            n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rand%0d_overrun: got %b required 0", r, overrun); end
        end
    endtask

    initial begin
        bus.sum_valid = 1'b0;
        bus.sum_in = '0;
        bus.bias_in = '0;
        bus.dout_ready = 1'b0;
        test_reset();
        test_pass_timing();
        test_relu_back_to_back();
        test_htanh();
        test_saturation();
        test_overrun();
        test_reset_mid_layer();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end
endmodule

// File: doc/batch_acc_act.md
Name: batch_acc_act

Overview:
- Downstream stage of the 16-lane multiply/adder-tree datapath.
- Consumes one `channel_sum` per BATCH_LENGTH-wide chunk and accumulates `cfg_batches` chunks per output neuron, then adds the neuron bias and applies the selected activation.
- Pushes each result into a small output FIFO that feeds the writeback/next-layer logic.
- The upstream tree cannot stall, so this block never back-pressures it; overruns are flagged instead.

Parameters:
- DW, 16: data width; signed fixed-point values.
- FRAC, 12: fractional bits of the fixed-point format; 1.0 = 1<<FRAC.
- CNT_W, 8: width of the batch and neuron counters.
- ACC_W, 24: accumulator width, signed; must be ≥ DW+4.
- FIFO_DEPTH, 4: output FIFO entries; power of two.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- start  in  1  one-cycle pulse; latches cfg_* and begins a layer.
- cfg_batches  in  CNT_W  chunks per neuron; 0 is treated as 1.
- cfg_neurons  in  CNT_W  neurons per layer; 0 is treated as 1.
- act_sel  in  2  00 pass, 01 ReLU, 10 hard-tanh, 11 pass.
- bias_in  in  DW  bias of the current neuron; sampled on the last chunk's sum_valid.
- sum_valid  in  1  channel_sum strobe from the adder tree.
- sum_in  in  DW  channel_sum, signed.
- dout  out  DW  result at the FIFO head.
- dout_valid  out  1  FIFO not empty.
- dout_ready  in  1  consumer accepts; pops when dout_valid && dout_ready.
- busy  out  1  layer in progress.
- done  out  1  one-cycle pulse when the last neuron is pushed.
- overrun  out  1  sticky; a result was dropped because the FIFO was full.
- bias_req  out  1  high while the current chunk is the last of its neuron.

Behaviour:
- Clock and reset: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: acc=0, counters=0, state IDLE, FIFO empty, dout=0, dout_valid=0, busy=0, done=0, overrun=0, bias_req=0.
- Reset mid-layer: everything is discarded, including FIFO contents.
- FSM has three states:
  - IDLE: start → ACC; clears overrun, batch_cnt, neuron_cnt, acc. sum_valid in IDLE is ignored.
  - ACC: on each sum_valid, sign-extend sum_in to ACC_W.
    - First chunk of a neuron (batch_cnt==0): acc<=sum. Otherwise: acc<=acc+sum.
    - batch_cnt increments; bias_req = (batch_cnt == cfg_batches-1).
    - Last chunk: stage register s1 <= acc_next + sext(bias_in); s1_v<=1; batch_cnt<=0; neuron_cnt++.
    - The next sum_valid (possibly the very next cycle) starts the next neuron; no bubble is required.
    - If the neuron just closed is the last one → DRAIN.
  - DRAIN: wait until s1_v and the activation stage are empty, then → IDLE; busy drops the same cycle.
- start while busy: ignored.
- Activation stage, registered (s2), one cycle after s1:
  - Pass: unchanged.
  - ReLU: negative → 0.
  - Hard-tanh: clamp to [-(1<<FRAC), +(1<<FRAC)].
  - Narrow from ACC_W to DW per the optional feature below.
- Latency: last-chunk sum_valid at cycle T → FIFO write at T+2 → dout_valid at T+3 if the FIFO was empty (registered output).
- done pulses at the FIFO-write cycle of the final neuron; it pulses even if that write is dropped.
- FIFO full at write time: the result is dropped and overrun<=1.
  - A pop in the same cycle as a write frees the slot, so the write succeeds.
- Simultaneous push and pop on an empty FIFO: the push is stored; dout_valid rises the next cycle.
- Wrap-around: FIFO pointers are log2(FIFO_DEPTH)+1 bits; full = MSBs differ and LSBs equal.

Optional Feature:
- Macro: BATCH_ACC_SAT_EN.
- Defined: narrowing saturates to [-2^(DW-1), 2^(DW-1)-1]; the accumulator also saturates at ACC_W limits.
- Undefined: narrowing takes the low DW bits (two's-complement wrap); the accumulator wraps.

Decomposition:
- Shared package nn_pkg holds:
  - the act_sel encodings ACT_PASS/ACT_RELU/ACT_HTANH;
  - the FSM state encodings;
  - the saturate function shared with other NN stages.
- Sub-module res_fifo: parameterised synchronous FIFO with registered output and full/empty flags.

Test Plan:
- batches=2, neurons=1, act=pass, bias=0x0100, sums 0x0200 then 0x0300 → dout=0x0600 at T+3, done pulse at T+2, busy low after.
- batches=1, neurons=3, ReLU, back-to-back sums 0x0100, 0xFF00, 0x0050, bias=0 → dout sequence 0x0100, 0x0000, 0x0050.
- Hard-tanh, FRAC=12, batches=1, sum=0x3000 → 0x1000; sum=0xC000 → 0xF000.
- SAT_EN defined, batches=4, sums 0x7000 each → 0x7FFF; undefined → low 16 bits of 0x1C000 = 0xC000.
- dout_ready=0, neurons=6, batches=1 → 4 results held, 2 dropped, overrun=1; later dout_ready=1 drains the first 4 in order.
- rst_n asserted mid-layer after 1 of 2 chunks → all outputs return to reset values immediately; a new start begins accumulation from 0.
